// File: rtl/multicycle_ctrl_if.sv
// Memory request/completion handshake between the multicycle controller and the memory.
interface multicycle_ctrl_if;
  logic memRead;
  logic memWrite;
  logic iord;
  logic memReady;

  modport master (output memRead, output memWrite, output iord, input memReady);
  modport slave  (input memRead, input memWrite, input iord, output memReady);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: fetch/decode/execute sequencing with a memory wait
// counter, sticky bus-error flag on memory timeout, and an illegal-opcode pulse in DECODE.
module multicycle_ctrl #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  multicycle_ctrl_if.master  memBus,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               branch,
  output logic               jump,
  output logic [2:0]         state,
  output logic               bus_err,
  output logic               illegal
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEMADDR = 3'd3,
    MEMACC  = 3'd4,
    WB      = 3'd5,
    BRANCH  = 3'd6,
    JUMP    = 3'd7
  } stateT;

  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(7);
  localparam logic [7:0]         WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  function automatic logic isRtype(input logic [5:0] op);
    return op == 6'b000000;
  endfunction

  function automatic logic isImm(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

  function automatic logic isLoad(input logic [5:0] op);
    return (op[5:3] == 3'b100) && (op[2:0] != 3'b111);
  endfunction

  function automatic logic isStore(input logic [5:0] op);
    return (op[5:3] == 3'b101) && (op[2:0] != 3'b111) &&
           (op[2:0] != 3'b100) && (op[2:0] != 3'b101);
  endfunction

  function automatic logic isBranch(input logic [5:0] op);
    return (op == 6'b000001) || (op[5:2] == 4'b0001);
  endfunction

  function automatic logic isJump(input logic [5:0] op);
    return op[5:1] == 5'b00001;
  endfunction

  function automatic logic [ALUOP_W-1:0] immAluOp(input logic [2:0] sub);
    logic [ALUOP_W-1:0] op;
    unique case (sub)
      3'd0, 3'd1: op = ALU_ADD;
      3'd2, 3'd3: op = ALU_SLT;
      3'd4:       op = ALU_AND;
      3'd5:       op = ALU_OR;
      3'd6:       op = ALU_XOR;
      default:    op = ALU_SLL;
    endcase
    return op;
  endfunction

  stateT      stateQ, stateD;
  logic [7:0] waitCnt, waitCntD;
  logic [5:0] opcodeQ;
  logic       busErrQ;
  logic       waiting;
  logic       timeout;

  // Only FETCH and MEMACC wait on memory; the limit cycle itself still accepts memReady.
  assign waiting = (stateQ == FETCH) || (stateQ == MEMACC);
  assign timeout = waiting && !memBus.memReady && (waitCnt == WAIT_LAST);

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      FETCH: begin
        if (memBus.memReady)  stateD = DECODE;
        else if (timeout)     stateD = FETCH;
      end
      DECODE: begin
        if (isRtype(opcode) || isImm(opcode))      stateD = EXEC;
        else if (isLoad(opcode) || isStore(opcode)) stateD = MEMADDR;
        else if (isBranch(opcode))                  stateD = BRANCH;
        else if (isJump(opcode))                    stateD = JUMP;
        else                                        stateD = FETCH;
      end
      EXEC:    stateD = WB;
      MEMADDR: stateD = MEMACC;
      MEMACC: begin
        if (memBus.memReady) stateD = isLoad(opcodeQ) ? WB : FETCH;
        else if (timeout)    stateD = FETCH;
      end
      WB, BRANCH, JUMP: stateD = FETCH;
      default: stateD = FETCH;
    endcase
  end

  // A timeout re-enters FETCH from FETCH, so it must clear the counter like a real entry.
  always_comb begin
    waitCntD = waitCnt;
    if (((stateD == FETCH) || (stateD == MEMACC)) && ((stateD != stateQ) || timeout))
      waitCntD = '0;
    else if (waiting && !memBus.memReady)
      waitCntD = waitCnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= FETCH;
      waitCnt <= '0;
      opcodeQ <= '0;
      busErrQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      waitCnt <= waitCntD;
      if (stateQ == DECODE) opcodeQ <= opcode;
      if (timeout)          busErrQ <= 1'b1;
    end
  end

  always_comb begin
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    memBus.memRead   = 1'b0;
    memBus.memWrite  = 1'b0;
    memBus.iord      = 1'b0;
    reg_write        = 1'b0;
    reg_dst          = 2'd0;
    mem_to_reg       = 2'd0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'd0;
    alu_op           = '0;
    branch           = 1'b0;
    jump             = 1'b0;
    illegal          = 1'b0;
    unique case (stateQ)
      FETCH: begin
        memBus.memRead = 1'b1;
        alu_src_b      = 2'd1;
        alu_op         = ALU_ADD;
        // Write strobes stay low while reset is held, even if memReady is high.
        if (memBus.memReady && rst_n) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        illegal   = !(isRtype(opcode) || isImm(opcode) || isLoad(opcode) ||
                      isStore(opcode) || isBranch(opcode) || isJump(opcode));
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = isRtype(opcodeQ) ? 2'd0 : 2'd2;
        alu_op    = isRtype(opcodeQ) ? ALU_RTYPE : immAluOp(opcodeQ[2:0]);
      end
      MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
      end
      MEMACC: begin
        memBus.iord     = 1'b1;
        memBus.memRead  = isLoad(opcodeQ);
        memBus.memWrite = isStore(opcodeQ);
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = isLoad(opcodeQ) ? 2'd1 : 2'd0;
        reg_dst    = isRtype(opcodeQ) ? 2'd1 : 2'd0;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
      JUMP: begin
        jump     = 1'b1;
        pc_write = 1'b1;
        if (opcodeQ[0]) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
      end
      default: ;
    endcase
  end

  assign state   = stateQ;
  assign bus_err = busErrQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level model expands each instruction
// into its expected per-cycle outputs; a single compare process checks them on every negedge.
module tb_multicycle_ctrl;
  localparam int TMO = 4;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          pc_write, ir_write, reg_write, alu_src_a, branch, jump, bus_err, illegal;
  logic [1:0]    reg_dst, mem_to_reg, alu_src_b;
  logic [AW-1:0] alu_op;
  logic [2:0]    state;

  multicycle_ctrl_if memIf ();

  multicycle_ctrl #(.ALUOP_W(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .memBus     (memIf),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .branch     (branch),
    .jump       (jump),
    .state      (state),
    .bus_err    (bus_err),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          pcW, irW, mr, mw, iord, rw;
    logic [1:0]    rd, m2r;
    logic          asa;
    logic [1:0]    asb;
    logic [AW-1:0] aop;
    logic          br, jmp, berr, ill;
  } expT;

  typedef struct {
    logic       rdy;
    logic [5:0] opc;
    expT        e;
  } planT;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } litT;

  typedef enum {C_R, C_IMM, C_LD, C_ST, C_BR, C_J, C_ILL} clsT;

  planT planQ[$];
  expT  expQ[$];
  litT  litQ[$];
  int   nTests = 0;
  int   nFail  = 0;
  logic checkEn = 1'b0;
  logic mBerr   = 1'b0;

  function automatic clsT classOf(input logic [5:0] op);
    int v = int'(op);
    if (v == 0)                                   return C_R;
    if (v >= 8 && v <= 15)                        return C_IMM;
    if (v >= 32 && v <= 38)                       return C_LD;
    if ((v >= 40 && v <= 43) || v == 46)          return C_ST;
    if (v == 1 || (v >= 4 && v <= 7))             return C_BR;
    if (v == 2 || v == 3)                         return C_J;
    return C_ILL;
  endfunction

  function automatic int immAlu(input logic [5:0] op);
    case (int'(op))
      8, 9:    return 1;
      10, 11:  return 6;
      12:      return 3;
      13:      return 4;
      14:      return 5;
      default: return 7;
    endcase
  endfunction

  function automatic expT blank(input int s);
    expT e = '0;
    e.st   = s[2:0];
    e.berr = mBerr;
    return e;
  endfunction

  function automatic expT fetchExp(input logic rdy);
    expT e = blank(0);
    e.mr  = 1'b1;
    e.asb = 2'd1;
    e.aop = AW'(1);
    e.pcW = rdy;
    e.irW = rdy;
    return e;
  endfunction

  function automatic logic [5:0] rndOp();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rndBit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic rdy, input logic [5:0] opc, input expT e);
    planT p;
    p.rdy = rdy;
    p.opc = opc;
    p.e   = e;
    planQ.push_back(p);
  endtask

  task automatic lit(input string name, input int act, input int exp);
    litT l;
    l.name = name;
    l.act  = act;
    l.exp  = exp;
    litQ.push_back(l);
  endtask

  // Expand one instruction into cycles; fw/mw are cycles of memReady=0 before completion.
  task automatic buildInstr(input logic [5:0] opc, input int fw, input int mw);
    clsT c = classOf(opc);
    expT e;
    int  n = (fw >= TMO) ? TMO : fw;
    for (int i = 0; i < n; i++) add(1'b0, rndOp(), fetchExp(1'b0));
    if (fw >= TMO) begin
      mBerr = 1'b1;
      return;
    end
    add(1'b1, rndOp(), fetchExp(1'b1));
    e = blank(1); e.asb = 2'd3; e.aop = AW'(1); e.ill = (c == C_ILL);
    add(rndBit(), opc, e);
    case (c)
      C_R, C_IMM: begin
        e = blank(2); e.asa = 1'b1;
        e.asb = (c == C_R) ? 2'd0 : 2'd2;
        e.aop = (c == C_R) ? AW'(0) : AW'(immAlu(opc));
        add(rndBit(), rndOp(), e);
        e = blank(5); e.rw = 1'b1; e.rd = (c == C_R) ? 2'd1 : 2'd0;
        add(rndBit(), rndOp(), e);
      end
      C_LD, C_ST: begin
        e = blank(3); e.asa = 1'b1; e.asb = 2'd2; e.aop = AW'(1);
        add(rndBit(), rndOp(), e);
        n = (mw >= TMO) ? TMO : mw;
        for (int i = 0; i <= n; i++) begin
          if (i == n && mw >= TMO) break;
          e = blank(4); e.iord = 1'b1; e.mr = (c == C_LD); e.mw = (c == C_ST);
          add((i == n), rndOp(), e);
        end
        if (mw >= TMO) begin
          mBerr = 1'b1;
          return;
        end
        if (c == C_LD) begin
          e = blank(5); e.rw = 1'b1; e.m2r = 2'd1;
          add(rndBit(), rndOp(), e);
        end
      end
      C_BR: begin
        e = blank(6); e.asa = 1'b1; e.aop = AW'(2); e.br = 1'b1;
        add(rndBit(), rndOp(), e);
      end
      C_J: begin
        e = blank(7); e.jmp = 1'b1; e.pcW = 1'b1;
        if (opc == 6'd3) begin
          e.rw = 1'b1; e.rd = 2'd2; e.m2r = 2'd2;
        end
        add(rndBit(), rndOp(), e);
      end
      default: ;
    endcase
  endtask

  task automatic play(input int n);
    planT p;
    for (int i = 0; i < n; i++) begin
      p = planQ.pop_front();
      memIf.memReady = p.rdy;
      opcode         = p.opc;
      expQ.push_back(p.e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic playAll();
    play(planQ.size());
  endtask

  always @(negedge clk) begin : compare
    litT l;
    expT e;
    expT a;
    while (litQ.size() > 0) begin
      l = litQ.pop_front();
      nTests++;
      if (l.act != l.exp) begin
        nFail++;
        $display("FAIL %s: got %0d want %0d", l.name, l.act, l.exp);
      end
    end
    if (checkEn && expQ.size() > 0) begin
      e = expQ.pop_front();
      a = {state, pc_write, ir_write, memIf.memRead, memIf.memWrite, memIf.iord, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, branch, jump, bus_err, illegal};
      nTests++;
      if (a !== e) begin
        nFail++;
        $display("FAIL cycle_outputs @%0t: got %h want %h (state got %0d want %0d)",
                 $time, a, e, a.st, e.st);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [5:0] stOps [5];
    logic [5:0] brOps [5];
    logic [5:0] op;
    int         fw, mw;
    stOps = '{6'd40, 6'd41, 6'd42, 6'd43, 6'd46};
    brOps = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd7};

    rst_n          = 1'b0;
    memIf.memReady = 1'b1;
    opcode         = 6'h3f;
    #12;
    lit("rst_state", int'(state), 0);
    lit("rst_mem_read", int'(memIf.memRead), 1);
    lit("rst_alu_src_b", int'(alu_src_b), 1);
    lit("rst_iord", int'(memIf.iord), 0);
    lit("rst_ir_write", int'(ir_write), 0);
    lit("rst_pc_write", int'(pc_write), 0);
    lit("rst_bus_err", int'(bus_err), 0);
    lit("rst_illegal", int'(illegal), 0);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    memIf.memReady = 1'b0;
    checkEn        = 1'b1;

    buildInstr(6'd0, 0, 0);  lit("rtype_cycles", planQ.size(), 4); playAll();
    buildInstr(6'd35, 0, 3); lit("lw_cycles", planQ.size(), 8);    playAll();
    buildInstr(6'd43, 0, 0); lit("sw_cycles", planQ.size(), 4);    playAll();
    buildInstr(6'd3, 0, 0);  lit("jal_cycles", planQ.size(), 3);   playAll();
    buildInstr(6'd4, 0, 0);  playAll();
    buildInstr(6'd63, 0, 0); lit("illegal_cycles", planQ.size(), 2); playAll();
    buildInstr(6'd8, TMO - 1, 0); playAll();
    lit("no_err_at_limit", int'(bus_err), 0);
    buildInstr(6'd0, TMO, 0); lit("fetch_timeout_cycles", planQ.size(), TMO); playAll();
    lit("bus_err_set", int'(bus_err), 1);
    buildInstr(6'd43, 0, TMO + 2); playAll();

    repeat (80) begin
      case ($urandom_range(0, 7))
        0:       op = 6'd0;
        1:       op = 6'(8 + $urandom_range(0, 7));
        2:       op = 6'(32 + $urandom_range(0, 6));
        3:       op = stOps[$urandom_range(0, 4)];
        4:       op = brOps[$urandom_range(0, 4)];
        5:       op = 6'(2 + $urandom_range(0, 1));
        default: op = rndOp();
      endcase
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 1)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO + 1)) : 0;
      buildInstr(op, fw, mw);
      playAll();
    end

    // Asynchronous reset in the middle of a load's memory access.
    buildInstr(6'd35, 0, 2);
    play(3);
    lit("pre_rst_state", int'(state), 4);
    lit("pre_rst_bus_err", int'(bus_err), 1);
    checkEn = 1'b0;
    planQ.delete();
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_rst_state", int'(state), 0);
    lit("async_rst_bus_err", int'(bus_err), 0);
    lit("async_rst_mem_read", int'(memIf.memRead), 1);
    lit("async_rst_iord", int'(memIf.iord), 0);
    lit("async_rst_mem_write", int'(memIf.memWrite), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mBerr   = 1'b0;
    checkEn = 1'b1;
    buildInstr(6'd35, 0, 1); playAll();
    buildInstr(6'd13, 1, 0); playAll();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
